// File: rtl/fp_intermediate_wb_collector_pkg.sv
// Shared types for the FP intermediate writeback path: the unrounded result
// record handed from arithmetic units to the normalise/round stage.
package fp_intermediate_wb_collector_pkg;

    localparam int GRS_WIDTH   = 3;
    localparam int EXPO_WIDTH  = 11;
    localparam int FRAC_WIDTH  = 52;
    localparam int ID_WIDTH    = 5;
    localparam int RD_WIDTH    = 5;
    localparam int CLZ_WIDTH   = $clog2(FRAC_WIDTH + 1);
    localparam int SHAMT_WIDTH = $clog2(FRAC_WIDTH + EXPO_WIDTH + 1);

    typedef struct packed {
        logic [ID_WIDTH-1:0]    id;
        logic [RD_WIDTH-1:0]    rd;
        logic                   expo_overflow;
        logic [4:0]             fflags;
        logic [2:0]             rm;
        logic                   carry;
        logic                   safe;
        logic                   hidden;
        logic [GRS_WIDTH-1:0]   grs;
        logic [CLZ_WIDTH-1:0]   clz;
        logic                   right_shift;
        logic [SHAMT_WIDTH-1:0] right_shift_amt;
        logic                   subnormal;
        logic                   ignore_max_expo;
        logic                   d2s;
    } fp_intermediate_t;

endpackage

// File: rtl/fp_intermediate_wb_collector_if.sv
// Producer done/ack/data bundle plus the valid/ready head toward normalise/round.
interface fp_intermediate_wb_collector_if #(
    parameter int NUM_UNITS = 4
);
    import fp_intermediate_wb_collector_pkg::*;

    logic [NUM_UNITS-1:0] unit_done;
    fp_intermediate_t     unit_data [NUM_UNITS];
    logic [NUM_UNITS-1:0] unit_ack;
    logic                 out_valid;
    fp_intermediate_t     out_data;
    logic                 out_ready;
    logic [1:0]           occupancy;

    modport master (
        output unit_done, unit_data, out_ready,
        input  unit_ack, out_valid, out_data, occupancy
    );

    modport slave (
        input  unit_done, unit_data, out_ready,
        output unit_ack, out_valid, out_data, occupancy
    );

endinterface

// File: rtl/fp_intermediate_wb_collector_arbiter.sv
// Combinational round-robin picker: first requester at or above ptr_i, wrapping.
// grant_o is suppressed when en_i is low; grant_idx_o is still reported.
module fp_wb_rr_arbiter #(
    parameter int NUM_UNITS = 4,
    parameter int IDX_W     = 2
) (
    input  logic [NUM_UNITS-1:0] req_i,
    input  logic [IDX_W-1:0]     ptr_i,
    input  logic                 en_i,
    output logic [NUM_UNITS-1:0] grant_o,
    output logic [IDX_W-1:0]     grant_idx_o
);

    always_comb begin : pick
        logic             found;
        int               j;
        logic [IDX_W-1:0] jj;
        grant_o     = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        j           = 0;
        jj          = '0;
        for (int k = 0; k < NUM_UNITS; k++) begin
            j = int'(ptr_i) + k;
            if (j >= NUM_UNITS) j = j - NUM_UNITS;
            jj = IDX_W'(j);
            if (!found && req_i[jj]) begin
                found       = 1'b1;
                grant_idx_o = jj;
                grant_o[jj] = en_i;
            end
        end
    end

endmodule

// File: rtl/fp_intermediate_wb_collector.sv
// Round-robin collector of intermediate FP results into a 2-entry register buffer.
// Acceptance depends only on registered occupancy, so out_ready never reaches unit_ack.
module fp_intermediate_wb_collector
    import fp_intermediate_wb_collector_pkg::*;
#(
    parameter int NUM_UNITS = 4,
    parameter int DEPTH     = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    fp_intermediate_wb_collector_if.slave wb
);

    localparam int IDX_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

    fp_intermediate_t     mem_q [2];
    logic                 head_q, tail_q;
    logic [1:0]           count_q, count_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [NUM_UNITS-1:0] grant;
    logic [IDX_W-1:0]     grant_idx;
    logic                 can_accept, push, pop;
    fp_intermediate_t     push_data;

    assign can_accept = (count_q < 2'(DEPTH)) && !rst;

    fp_wb_rr_arbiter #(
        .NUM_UNITS(NUM_UNITS),
        .IDX_W    (IDX_W)
    ) u_arb (
        .req_i      (wb.unit_done),
        .ptr_i      (ptr_q),
        .en_i       (can_accept),
        .grant_o    (grant),
        .grant_idx_o(grant_idx)
    );

    assign wb.unit_ack = grant;
    assign push        = |grant;
    assign pop         = (count_q != 2'd0) && wb.out_ready;

    // One-hot grant selects the payload with an AND-OR mux.
    always_comb begin
        push_data = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            if (grant[i]) push_data = push_data | wb.unit_data[i];
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (push) ptr_d = (grant_idx == IDX_W'(NUM_UNITS - 1)) ? '0 : grant_idx + 1'b1;
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            head_q   <= 1'b0;
            tail_q   <= 1'b0;
            count_q  <= 2'd0;
            ptr_q    <= '0;
        end else begin
            if (push) begin
                mem_q[tail_q] <= push_data;
                tail_q        <= ~tail_q;
            end
            if (pop) head_q <= ~head_q;
            count_q <= count_d;
            ptr_q   <= ptr_d;
        end
    end

    assign wb.out_valid = (count_q != 2'd0);
    assign wb.out_data  = mem_q[head_q];
    assign wb.occupancy = count_q;

    a_ack_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(wb.unit_ack));
    a_ack_done:   assert property (@(posedge clk) disable iff (rst) (wb.unit_ack & ~wb.unit_done) == '0);
    a_occ_max:    assert property (@(posedge clk) disable iff (rst) count_q <= 2'd2);

endmodule

// File: tb/tb_fp_intermediate_wb_collector.sv
// Directed bench for the intermediate writeback collector.
module tb_fp_intermediate_wb_collector;
    import fp_intermediate_wb_collector_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   ack_cnt [4];

    always #5 clk = ~clk;

    fp_intermediate_wb_collector_if #(.NUM_UNITS(4)) bus ();

    fp_intermediate_wb_collector #(.NUM_UNITS(4), .DEPTH(2)) dut (
        .clk(clk),
        .rst(rst),
        .wb (bus)
    );

    function automatic fp_intermediate_t mk(input logic [4:0] id);
        fp_intermediate_t r;
        r                 = '0;
        r.id              = id;
        r.rd              = ~id;
        r.fflags          = id;
        r.rm              = id[2:0];
        r.grs             = id[2:0];
        r.clz             = {1'b0, id};
        r.right_shift_amt = {1'b0, id};
        r.d2s             = id[0];
        r.carry           = id[1];
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.unit_done = '0;
        bus.out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        bus.unit_done = 4'b1111;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) bus.unit_data[i] = mk(5'(i + 1));

        // reset held with every producer requesting
        step();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("rst_ack", 64'(bus.unit_ack), 64'd0);
            check("rst_valid", 64'(bus.out_valid), 64'd0);
            check("rst_occ", 64'(bus.occupancy), 64'd0);
            check("rst_data", 64'(bus.out_data), 64'd0);
            step();
        end
        rst           = 1'b0;
        bus.unit_done = '0;
        step();

        // single transfer from unit 2
        bus.unit_done    = 4'b0100;
        bus.unit_data[2] = mk(5'd5);
        bus.out_ready    = 1'b1;
        @(negedge clk);
        check("single_ack", 64'(bus.unit_ack), 64'b0100);
        check("single_v0", 64'(bus.out_valid), 64'd0);
        step();
        bus.unit_done = '0;
        @(negedge clk);
        check("single_v1", 64'(bus.out_valid), 64'd1);
        check("single_id", 64'(bus.out_data.id), 64'd5);
        check("single_ack1", 64'(bus.unit_ack), 64'd0);
        step();
        @(negedge clk);
        check("single_occ", 64'(bus.occupancy), 64'd0);
        check("single_v2", 64'(bus.out_valid), 64'd0);
        step();

        // fairness with all producers requesting
        do_reset();
        for (int i = 0; i < 4; i++) begin
            bus.unit_data[i] = mk(5'(16 + i));
            ack_cnt[i]       = 0;
        end
        bus.unit_done = 4'b1111;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("rr_ack", 64'(bus.unit_ack), 64'(4'b0001 << (k % 4)));
            for (int i = 0; i < 4; i++) if (bus.unit_ack[i]) ack_cnt[i]++;
            if (k >= 1) begin
                check("rr_occ", 64'(bus.occupancy), 64'd1);
                check("rr_head", 64'(bus.out_data.id), 64'(16 + (k - 1) % 4));
            end
            step();
        end
        for (int i = 0; i < 4; i++) check("rr_share", 64'(ack_cnt[i]), 64'd2);
        bus.unit_done = '0;

        // backpressure: fill to two, stall, then drain in order
        do_reset();
        bus.unit_done    = 4'b0011;
        bus.unit_data[0] = mk(5'd1);
        bus.unit_data[1] = mk(5'd2);
        @(negedge clk);
        check("bp_ack0", 64'(bus.unit_ack), 64'b0001);
        step();
        bus.unit_data[0] = mk(5'd10);
        @(negedge clk);
        check("bp_ack1", 64'(bus.unit_ack), 64'b0010);
        check("bp_occ1", 64'(bus.occupancy), 64'd1);
        step();
        bus.unit_data[1] = mk(5'd11);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check("bp_noack", 64'(bus.unit_ack), 64'd0);
            check("bp_occ2", 64'(bus.occupancy), 64'd2);
            check("bp_head", 64'(bus.out_data.id), 64'd1);
            step();
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp_full_pop_noack", 64'(bus.unit_ack), 64'd0);
        check("bp_pop0", 64'(bus.out_data.id), 64'd1);
        step();
        @(negedge clk);
        check("bp_pop1", 64'(bus.out_data.id), 64'd2);
        check("bp_resume", 64'(bus.unit_ack), 64'b0001);
        step();
        bus.unit_done = '0;
        @(negedge clk);
        check("bp_pop2", 64'(bus.out_data.id), 64'd10);
        check("bp_occ_end", 64'(bus.occupancy), 64'd1);
        step();
        @(negedge clk);
        check("bp_empty", 64'(bus.out_valid), 64'd0);
        step();

        // simultaneous push and pop at occupancy 1
        do_reset();
        bus.unit_done    = 4'b0010;
        bus.unit_data[1] = mk(5'd7);
        @(negedge clk);
        check("pp_ack1", 64'(bus.unit_ack), 64'b0010);
        step();
        bus.unit_done    = 4'b1000;
        bus.unit_data[3] = mk(5'd9);
        bus.out_ready    = 1'b1;
        @(negedge clk);
        check("pp_occ_a", 64'(bus.occupancy), 64'd1);
        check("pp_head_a", 64'(bus.out_data.id), 64'd7);
        check("pp_ack3", 64'(bus.unit_ack), 64'b1000);
        step();
        bus.unit_done = '0;
        @(negedge clk);
        check("pp_occ_b", 64'(bus.occupancy), 64'd1);
        check("pp_data", 64'(bus.out_data), 64'(mk(5'd9)));
        step();
        @(negedge clk);
        check("pp_occ_c", 64'(bus.occupancy), 64'd0);
        step();

        // reset while full
        do_reset();
        bus.unit_done    = 4'b0011;
        bus.unit_data[0] = mk(5'd1);
        bus.unit_data[1] = mk(5'd2);
        step();
        bus.unit_done = 4'b0010;
        step();
        bus.unit_done = '0;
        @(negedge clk);
        check("mr_occ_full", 64'(bus.occupancy), 64'd2);
        step();
        rst = 1'b1;
        step();
        rst           = 1'b0;
        bus.unit_done = 4'b1111;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("mr_valid", 64'(bus.out_valid), 64'd0);
        check("mr_occ", 64'(bus.occupancy), 64'd0);
        check("mr_data", 64'(bus.out_data), 64'd0);
        check("mr_ptr", 64'(bus.unit_ack), 64'b0001);
        step();
        bus.unit_done = '0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
